// File: rtl/uart_rx_fsm.sv
// UART receive controller: oversampling edge counter, bit counter and the
// START/DATA/PARITY/STOP sequencer that drives the sampler and checkers.
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      STRT_GLITCH,
    input  logic                      PAR_ERR,
    input  logic                      STP_ERR,
    output logic                      DAT_SAMP_EN,
    output logic [PRESCALE_WIDTH-1:0] EDGE_CNT,
    output logic [3:0]                BIT_CNT,
    output logic                      DESER_EN,
    output logic                      STRT_CHK_EN,
    output logic                      PAR_CHK_EN,
    output logic                      STP_CHK_EN,
    output logic                      DATA_VALID,
    output logic                      FRAME_ERR,
    output logic [2:0]                STATE_DBG
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
    logic [PRESCALE_WIDTH-1:0] p_q, p_d;
    logic [PRESCALE_WIDTH-1:0] p_sel;
    logic [3:0]                bit_q, bit_d;
    logic                      sticky_q, sticky_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      edge_last;
    logic                      edge_chk;

    // Checkers sample at P-2 and present their registered verdict at P-1.
    assign edge_last = (edge_q == p_q - PRESCALE_WIDTH'(1));
    assign edge_chk  = (edge_q == p_q - PRESCALE_WIDTH'(2));

    always_comb begin
        p_sel = PRESCALE_WIDTH'(8);
        if (PRESCALE == PRESCALE_WIDTH'(16) || PRESCALE == PRESCALE_WIDTH'(32)) begin
            p_sel = PRESCALE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            edge_q   <= '0;
            p_q      <= PRESCALE_WIDTH'(8);
            bit_q    <= '0;
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            edge_q   <= edge_d;
            p_q      <= p_d;
            bit_q    <= bit_d;
            sticky_q <= sticky_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        edge_d   = edge_last ? '0 : edge_q + PRESCALE_WIDTH'(1);
        p_d      = p_q;
        bit_d    = bit_q;
        sticky_d = sticky_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!RX_IN) begin
                    state_d  = START;
                    p_d      = p_sel;
                    sticky_d = 1'b0;
                end
            end
            START: begin
                if (edge_last) begin
                    state_d = STRT_GLITCH ? IDLE : DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (edge_last) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = PAR_EN ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (edge_last) begin
                    sticky_d = PAR_ERR;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (edge_last) begin
                    state_d = IDLE;
                    if (!STP_ERR && !sticky_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign DAT_SAMP_EN = (state_q != IDLE);
    assign EDGE_CNT    = edge_q;
    assign BIT_CNT     = bit_q;
    assign DESER_EN    = (state_q == DATA)   && edge_chk;
    assign STRT_CHK_EN = (state_q == START)  && edge_chk;
    assign PAR_CHK_EN  = (state_q == PARITY) && edge_chk;
    assign STP_CHK_EN  = (state_q == STOP)   && edge_chk;
    assign DATA_VALID  = valid_q;
    assign FRAME_ERR   = ferr_q;
    assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: table of frames checked cycle by cycle against a
// closed-form timing model, with end-of-frame pulses tracked in a queue.
module tb_uart_rx_fsm;

    typedef struct {
        logic [5:0] p_in;
        logic [5:0] p_mid;
        int         exp_p;
        bit         par_en;
        logic [7:0] data;
        bit         par_err;
        bit         stp_err;
        bit         glitch;
        logic [1:0] exp_kind;
    } vec_t;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] PRESCALE;
    logic       STRT_GLITCH;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       DAT_SAMP_EN;
    logic [5:0] EDGE_CNT;
    logic [3:0] BIT_CNT;
    logic       DESER_EN;
    logic       STRT_CHK_EN;
    logic       PAR_CHK_EN;
    logic       STP_CHK_EN;
    logic       DATA_VALID;
    logic       FRAME_ERR;
    logic [2:0] STATE_DBG;

    int total;
    int bad;
    int cyc;
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    vec_t tbl[10];

    uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PRESCALE(PRESCALE),
        .STRT_GLITCH(STRT_GLITCH), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
        .DAT_SAMP_EN(DAT_SAMP_EN), .EDGE_CNT(EDGE_CNT), .BIT_CNT(BIT_CNT),
        .DESER_EN(DESER_EN), .STRT_CHK_EN(STRT_CHK_EN), .PAR_CHK_EN(PAR_CHK_EN),
        .STP_CHK_EN(STP_CHK_EN), .DATA_VALID(DATA_VALID), .FRAME_ERR(FRAME_ERR),
        .STATE_DBG(STATE_DBG)
    );

    // Clock and cycle counter
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Expected per-cycle outputs at offset k from the first START cycle.
    function automatic logic [17:0] model(int k, int p, bit par);
        int n, b, e;
        logic [2:0] st;
        logic [3:0] bc;
        logic chk;
        n = par ? 11 : 10;
        if (k < 0 || k >= n * p) return '0;
        b = k / p;
        e = k % p;
        if (b == 0) st = 3'd1;
        else if (b <= 8) st = 3'd2;
        else if (b == 9 && par) st = 3'd3;
        else st = 3'd4;
        bc = (st == 3'd2) ? 4'(b - 1) : 4'd0;
        chk = (e == p - 2);
        return {st, 1'b1, 6'(e), bc, chk && st == 3'd2, chk && st == 3'd1,
                chk && st == 3'd3, chk && st == 3'd4};
    endfunction

    task automatic check_vec(input string name, input logic [17:0] exp_v);
        logic [17:0] act;
        act = {STATE_DBG, DAT_SAMP_EN, EDGE_CNT, BIT_CNT, DESER_EN, STRT_CHK_EN,
               PAR_CHK_EN, STP_CHK_EN};
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp_v);
        end
    endtask

    task automatic check_pulses_zero(input string name);
        total++;
        if ({FRAME_ERR, DATA_VALID} !== 2'b00) begin
            bad++;
            $display("FAIL %s pulses got=%b want=00", name, {FRAME_ERR, DATA_VALID});
        end
    endtask

    // Scoreboard: every end-of-frame pulse must match the head of exp_q.
    always @(negedge CLK) begin
        if (DATA_VALID || FRAME_ERR) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc,
                         {FRAME_ERR, DATA_VALID});
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e !== {FRAME_ERR, DATA_VALID, 32'(cyc)}) begin
                    bad++;
                    $display("FAIL pulse got=%b@%0d want=%b@%0d", {FRAME_ERR, DATA_VALID},
                             cyc, mon_e[33:32], mon_e[31:0]);
                end
            end
        end else if (exp_q.size() > 0 && int'(exp_q[0][31:0]) <= cyc) begin
            total++;
            bad++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_pulse cyc=%0d got=none want=%b@%0d", cyc,
                     mon_e[33:32], mon_e[31:0]);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            check_vec("idle", '0);
            RX_IN = 1'b1;
            STRT_GLITCH = 1'b0;
            PAR_ERR = 1'b0;
            STP_ERR = 1'b0;
        end
    endtask

    // Called at a negedge of an IDLE cycle; drives the start bit this cycle.
    task automatic do_frame(input vec_t r, input bit b2b_next);
        int t0, n, last, ep, b;
        ep = r.exp_p;
        n = r.par_en ? 11 : 10;
        last = r.glitch ? ep : n * ep;
        PRESCALE = r.p_in;
        PAR_EN = r.par_en;
        RX_IN = 1'b0;
        STRT_GLITCH = 1'b0;
        PAR_ERR = 1'b0;
        STP_ERR = 1'b0;
        t0 = cyc + 1;
        if (r.exp_kind != 2'b00) exp_q.push_back({r.exp_kind, 32'(t0 + n * ep)});
        for (int k = 0; k <= last; k++) begin
            @(negedge CLK);
            check_vec("frame", (k == last) ? 18'b0 : model(k, ep, r.par_en));
            if (k == last && b2b_next) return;
            b = k / ep;
            if (k == last) RX_IN = 1'b1;
            else if (b == 0) RX_IN = 1'b0;
            else if (b <= 8) RX_IN = r.data[b-1];
            else if (b == 9 && r.par_en) RX_IN = ^r.data;
            else RX_IN = 1'b1;
            STRT_GLITCH = r.glitch && (k == ep - 1);
            PAR_ERR = r.par_err && (r.par_en ? (k == (n - 1) * ep - 1) : 1'b1);
            STP_ERR = r.stp_err && (k == n * ep - 1);
            if (r.p_mid != 6'd0 && k == 20) PRESCALE = r.p_mid;
        end
    endtask

    initial begin
        int t0;
        // p_in, p_mid, exp_p, par_en, data, par_err, stp_err, glitch, exp_kind
        tbl[0] = '{6'd8,  6'd0,  8,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[1] = '{6'd16, 6'd0,  16, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[2] = '{6'd8,  6'd0,  8,  1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[3] = '{6'd8,  6'd0,  8,  1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 2'b10};
        tbl[4] = '{6'd8,  6'd0,  8,  1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[5] = '{6'd8,  6'd0,  8,  1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 2'b10};
        tbl[6] = '{6'd32, 6'd0,  32, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[7] = '{6'd12, 6'd0,  8,  1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[8] = '{6'd8,  6'd16, 8,  1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 2'b01};
        tbl[9] = '{6'd8,  6'd0,  8,  1'b0, 8'h69, 1'b1, 1'b0, 1'b0, 2'b01};

        total = 0;
        bad = 0;
        cyc = 0;
        RST = 1'b0;
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        PRESCALE = 6'd8;
        STRT_GLITCH = 1'b0;
        PAR_ERR = 1'b0;
        STP_ERR = 1'b0;
        repeat (2) @(negedge CLK);
        check_vec("reset", '0);
        check_pulses_zero("reset");
        RST = 1'b1;
        idle(3);

        for (int i = 0; i < 10; i++) begin
            do_frame(tbl[i], 1'b0);
            idle($urandom_range(2, 6));
        end

        // Back-to-back: second start bit sits in the first frame's pulse cycle.
        do_frame(tbl[0], 1'b1);
        do_frame(tbl[4], 1'b0);
        idle(4);

        // Reset mid-DATA: everything clears at once and no pulse follows.
        PRESCALE = 6'd8;
        PAR_EN = 1'b1;
        RX_IN = 1'b0;
        t0 = cyc + 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            check_vec("pre_rst", model(k, 8, 1'b1));
            RX_IN = 1'b1;
        end
        @(negedge CLK);
        check_vec("pre_rst", model(cyc - t0, 8, 1'b1));
        RST = 1'b0;
        #1;
        check_vec("rst_mid", '0);
        check_pulses_zero("rst_mid");
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        idle(20);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_pulses got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
